// File: rtl/drsstc_pkg.sv
// Shared types and helpers for the DRSSTC interrupter/burst timing blocks.
package drsstc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ON,
        OFF,
        FAULT
    } state_t;

    // Converts a duration in microseconds into clock cycles.
    function automatic int us_to_cycles(input int us, input int clk_mhz);
        return us * clk_mhz;
    endfunction

    // Largest of three durations, used to size the shared microsecond counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/us_prescaler.sv
// Microsecond prescaler: divides clk by CLK_MHZ and emits a one-cycle us_tick
// on the last count. clr restarts the count so a timed interval begins aligned
// with the event that started it.
module us_prescaler #(
    parameter int CLK_MHZ = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic us_tick
);

    localparam int PW = (CLK_MHZ > 1) ? $clog2(CLK_MHZ) : 1;
    localparam logic [PW-1:0] LAST = PW'(CLK_MHZ - 1);

    logic [PW-1:0] count;

    // Free-running 0..CLK_MHZ-1 counter, restarted by clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign us_tick = (count == LAST);

endmodule

// File: rtl/burst_sequencer.sv
// Burst sequencer: turns interrupter trigger edges into bounded, microsecond
// timed enable bursts with an enforced off-time and an overcurrent lockout.
// Optional macro BURST_FAULT_LATCH_EN: the lockout only ends on a fault_clr
// pulse after the hold has expired with ocd low; otherwise it auto-retries.
module burst_sequencer
    import drsstc_pkg::*;
#(
    parameter int CLK_MHZ        = 100,
    parameter int ON_TIME_MAX_US = 200,
    parameter int OFF_MIN_US     = 1000,
    parameter int FAULT_HOLD_US  = 10000,
    parameter int ON_W           = $clog2(ON_TIME_MAX_US + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            trig,
    input  logic [ON_W-1:0] on_us,
    input  logic            ocd,
    input  logic            fault_clr,
    output logic            en,
    output logic            busy,
    output logic            fault,
    output logic            drop
);

    localparam int CNT_MAX = max3(ON_TIME_MAX_US, OFF_MIN_US, FAULT_HOLD_US);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t            state;
    state_t            next_state;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic [CNT_W-1:0]  on_eff;
    logic              trig_pre;
    logic              trig_edge;
    logic              drop_next;
    logic              load;
    logic              us_tick;
    logic              expire;

`ifndef BURST_FAULT_LATCH_EN
    logic unused_fault_clr;
    assign unused_fault_clr = fault_clr;
`endif

    assign trig_edge = trig && !trig_pre;
    assign on_eff    = (on_us > ON_W'(ON_TIME_MAX_US)) ? CNT_W'(ON_TIME_MAX_US) : CNT_W'(on_us);
    assign expire    = us_tick && (cnt <= CNT_W'(1));

    us_prescaler #(
        .CLK_MHZ (CLK_MHZ)
    ) u_prescaler (
        .clk     (clk),
        .rst     (rst),
        .clr     (load),
        .us_tick (us_tick)
    );

    // Next-state, counter reload and drop decision; ocd overrides everything.
    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        load       = 1'b0;
        drop_next  = trig_edge;
        if (us_tick && cnt != '0) begin
            cnt_next = cnt - 1'b1;
        end
        if (ocd) begin
            next_state = FAULT;
            cnt_next   = CNT_W'(FAULT_HOLD_US);
            load       = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (trig_edge && on_eff != '0) begin
                        next_state = ON;
                        cnt_next   = on_eff;
                        load       = 1'b1;
                        drop_next  = 1'b0;
                    end
                end
                ON: begin
                    if (expire) begin
                        next_state = OFF;
                        cnt_next   = CNT_W'(OFF_MIN_US);
                        load       = 1'b1;
                    end
                end
                OFF: begin
                    if (expire) begin
                        next_state = IDLE;
                        cnt_next   = '0;
                        load       = 1'b1;
                    end
                end
                FAULT: begin
`ifdef BURST_FAULT_LATCH_EN
                    if (cnt == '0 && fault_clr) begin
`else
                    if (expire) begin
`endif
                        next_state = IDLE;
                        cnt_next   = '0;
                        load       = 1'b1;
                    end
                end
                default: begin
                    next_state = IDLE;
                    cnt_next   = '0;
                    load       = 1'b1;
                end
            endcase
        end
    end

    // State, counter, trigger history and drop pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            trig_pre <= 1'b1;
            drop     <= 1'b0;
        end else begin
            state    <= next_state;
            cnt      <= cnt_next;
            trig_pre <= trig;
            drop     <= drop_next;
        end
    end

    assign en    = (state == ON);
    assign busy  = (state == ON) || (state == OFF);
    assign fault = (state == FAULT);

endmodule

// File: tb/tb_burst_sequencer.sv
// Self-checking bench for burst_sequencer: a cycle-level model of bursts,
// off-time and fault lockout is compared against the DUT on every cycle,
// with directed scenarios pinned by literal counts and a randomized phase.
module tb_burst_sequencer;

    localparam int CLK_MHZ = 10;
    localparam int ON_MAX  = 20;
    localparam int OFF_MIN = 5;
    localparam int HOLD    = 8;
    localparam int ON_W    = $clog2(ON_MAX + 1);

    localparam int M_IDLE  = 0;
    localparam int M_ON    = 1;
    localparam int M_OFF   = 2;
    localparam int M_FAULT = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            trig = 1'b0;
    logic [ON_W-1:0] on_us = '0;
    logic            ocd = 1'b0;
    logic            fault_clr = 1'b0;
    logic            en;
    logic            busy;
    logic            fault;
    logic            drop;

    int n_cmp = 0;
    int n_bad = 0;
    int cnt_en = 0;
    int cnt_busy = 0;
    int cnt_fault = 0;
    int cnt_drop = 0;

    int m_mode = M_IDLE;
    int m_rem  = 0;
    bit m_prev = 1'b1;
    bit m_drop = 1'b0;

    always #5 clk = ~clk;

    burst_sequencer #(
        .CLK_MHZ        (CLK_MHZ),
        .ON_TIME_MAX_US (ON_MAX),
        .OFF_MIN_US     (OFF_MIN),
        .FAULT_HOLD_US  (HOLD),
        .ON_W           (ON_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .trig      (trig),
        .on_us     (on_us),
        .ocd       (ocd),
        .fault_clr (fault_clr),
        .en        (en),
        .busy      (busy),
        .fault     (fault),
        .drop      (drop)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit t, input int on, input bit o, input bit c);
        @(posedge clk);
        #2;
        trig      = t;
        on_us     = ON_W'(on);
        ocd       = o;
        fault_clr = c;
    endtask

    task automatic runCycles(input int n);
        repeat (n) applyStimulus(trig, int'(on_us), 1'b0, 1'b0);
    endtask

    task automatic clearCounts();
        cnt_en = 0;
        cnt_busy = 0;
        cnt_fault = 0;
        cnt_drop = 0;
    endtask

    // Behavioural model: durations tracked directly in clock cycles.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = M_IDLE;
            m_rem  = 0;
            m_prev = 1'b1;
            m_drop = 1'b0;
        end else begin
            bit t_edge;
            bit started;
            int eff;
            t_edge  = trig && !m_prev;
            started = 1'b0;
            eff     = (int'(on_us) > ON_MAX) ? ON_MAX : int'(on_us);
            if (ocd) begin
                m_mode = M_FAULT;
                m_rem  = HOLD * CLK_MHZ;
            end else begin
                case (m_mode)
                    M_IDLE: if (t_edge && eff != 0) begin
                        m_mode  = M_ON;
                        m_rem   = eff * CLK_MHZ;
                        started = 1'b1;
                    end
                    M_ON: if (m_rem == 1) begin
                        m_mode = M_OFF;
                        m_rem  = OFF_MIN * CLK_MHZ;
                    end else m_rem--;
                    M_OFF: if (m_rem == 1) m_mode = M_IDLE;
                           else m_rem--;
                    default: begin
`ifdef BURST_FAULT_LATCH_EN
                        if (m_rem > 0) m_rem--;
                        else if (fault_clr) m_mode = M_IDLE;
`else
                        if (m_rem == 1) m_mode = M_IDLE;
                        else m_rem--;
`endif
                    end
                endcase
            end
            m_drop = t_edge && !started;
            m_prev = trig;
        end
    end

    // Per-cycle comparison against the model, plus output occupancy counts.
    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("en", en, m_mode == M_ON);
            checkOutput("busy", busy, m_mode == M_ON || m_mode == M_OFF);
            checkOutput("fault", fault, m_mode == M_FAULT);
            checkOutput("drop", drop, m_drop);
            if (en === 1'b1) cnt_en++;
            if (busy === 1'b1) cnt_busy++;
            if (fault === 1'b1) cnt_fault++;
            if (drop === 1'b1) cnt_drop++;
        end
    end

    initial begin
        $display("[TB] start");
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_en", en, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_fault", fault, 0);
        checkOutput("reset_drop", drop, 0);
        applyStimulus(1'b0, 0, 1'b0, 1'b0);
        rst = 1'b0;
        runCycles(3);

        // Basic 3 us burst
        clearCounts();
        applyStimulus(1'b1, 3, 1'b0, 1'b0);
        runCycles(100);
        checkOutput("s1_en_cycles", cnt_en, 30);
        checkOutput("s1_busy_cycles", cnt_busy, 80);

        // Clamped burst, then a zero-length request
        applyStimulus(1'b0, 31, 1'b0, 1'b0);
        clearCounts();
        applyStimulus(1'b1, 31, 1'b0, 1'b0);
        runCycles(300);
        checkOutput("s2_en_cycles", cnt_en, 200);
        checkOutput("s2_busy_cycles", cnt_busy, 250);
        applyStimulus(1'b0, 0, 1'b0, 1'b0);
        clearCounts();
        applyStimulus(1'b1, 0, 1'b0, 1'b0);
        runCycles(10);
        checkOutput("s2_zero_en", cnt_en, 0);
        checkOutput("s2_zero_drop", cnt_drop, 1);

        // Edges during ON and OFF are dropped and not queued
        applyStimulus(1'b0, 5, 1'b0, 1'b0);
        clearCounts();
        applyStimulus(1'b1, 5, 1'b0, 1'b0);
        runCycles(19);
        applyStimulus(1'b0, 5, 1'b0, 1'b0);
        applyStimulus(1'b1, 5, 1'b0, 1'b0);
        runCycles(48);
        applyStimulus(1'b0, 5, 1'b0, 1'b0);
        applyStimulus(1'b1, 5, 1'b0, 1'b0);
        runCycles(150);
        checkOutput("s3_drop_count", cnt_drop, 2);
        checkOutput("s3_en_cycles", cnt_en, 50);
        checkOutput("s3_busy_cycles", cnt_busy, 100);

        // Overcurrent pulse during ON, with an early fault_clr
        applyStimulus(1'b0, 20, 1'b0, 1'b0);
        clearCounts();
        applyStimulus(1'b1, 20, 1'b0, 1'b0);
        runCycles(11);
        applyStimulus(1'b1, 20, 1'b1, 1'b0);
        runCycles(30);
        applyStimulus(1'b1, 20, 1'b0, 1'b1);
        runCycles(100);
        checkOutput("s4_en_cycles", cnt_en, 12);
`ifdef BURST_FAULT_LATCH_EN
        checkOutput("s4_fault_latched", fault, 1);
        applyStimulus(1'b0, 20, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("s4_fault_cleared", fault, 0);
`else
        checkOutput("s4_fault_cycles", cnt_fault, 80);
`endif
        runCycles(5);

        // Overcurrent held for 25 cycles
        clearCounts();
        repeat (25) applyStimulus(1'b0, 0, 1'b1, 1'b0);
        runCycles(150);
`ifdef BURST_FAULT_LATCH_EN
        checkOutput("s4_held_latched", fault, 1);
        applyStimulus(1'b0, 0, 1'b0, 1'b1);
        runCycles(3);
`else
        checkOutput("s4_held_fault_cycles", cnt_fault, 104);
`endif

        // Reset mid-burst with trig held high through release
        applyStimulus(1'b1, 10, 1'b0, 1'b0);
        runCycles(10);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("s5_rst_en", en, 0);
        checkOutput("s5_rst_busy", busy, 0);
        runCycles(3);
        rst = 1'b0;
        clearCounts();
        runCycles(30);
        checkOutput("s5_no_burst", cnt_en, 0);
        applyStimulus(1'b0, 10, 1'b0, 1'b0);
        applyStimulus(1'b1, 10, 1'b0, 1'b0);
        runCycles(5);
        #1;
        checkOutput("s5_new_burst", en, 1);
        runCycles(200);

        // Randomized traffic against the model
        for (int i = 0; i < 6000; i++) begin
            bit t;
            t = ($urandom_range(0, 19) == 0) ? !trig : trig;
            applyStimulus(t, int'($urandom_range(0, 31)),
                          $urandom_range(0, 299) == 0,
                          $urandom_range(0, 39) == 0);
        end
        runCycles(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
